cpu_core: RTL

Parametrised single-issue 16-bit-instruction CPU core, the successor to the three-opcode test CPU. It replaces the hardwired register width with a parameter, adds a reset, and adds subtract, conditional branch, halt and load/store over a handshaked data-memory port. It sits between the combinational instruction memory and a data memory or bus, and exposes debug and status outputs to the bench.

---
 rtl/cpu_core.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/cpu_core.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_core
//  Description : Single-issue 16-bit-instruction CPU core with a parametrised
//                datapath, 16-entry register file, conditional branch, halt
//                and load/store over a ready-handshaked data-memory port.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_core #(
  parameter int DATA_W   = 16,
  parameter int PC_W     = 16,
  parameter int RESET_PC = 0,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [15:0]       imem_data,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic [3:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data,
  output logic [PC_W-1:0]   pc,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_MEM  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [3:0] OP_MOV = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_JMP = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JZ  = 4'h4;
  localparam logic [3:0] OP_LD  = 4'h5;
  localparam logic [3:0] OP_ST  = 4'h6;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [CNT_W-1:0]    retired_q, retired_d;
  logic [DATA_W-1:0]   regs_q [16];
  logic [DATA_W-1:0]   regs_d [16];
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [3:0]          ld_rt_q, ld_rt_d;

  // Instruction field decode and register operand read (old values).
  logic [3:0]          op, ra, rb, rt;
  logic [DATA_W-1:0]   rs_a, rs_b;
  logic [PC_W-1:0]     pc_inc, jz_off;

  assign op     = imem_data[15:12];
  assign ra     = imem_data[11:8];
  assign rb     = imem_data[7:4];
  assign rt     = imem_data[3:0];
  assign rs_a   = regs_q[ra];
  assign rs_b   = regs_q[rb];
  assign pc_inc = pc_q + PC_W'(1);
  // Branch offset is a signed byte, sign-extended to the PC width.
  assign jz_off = PC_W'($signed(imem_data[7:0]));

  // Next-state, datapath and memory-request logic for the RUN/MEM/HALT FSM.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    regs_d    = regs_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    ld_rt_d   = ld_rt_q;

    case (state_q)
      S_RUN: begin
        pc_d      = pc_inc;
        retired_d = retired_q + CNT_W'(1);
        case (op)
          OP_MOV: regs_d[rt] = DATA_W'(imem_data[11:4]);
          OP_ADD: regs_d[rt] = rs_a + rs_b;
          OP_SUB: regs_d[rt] = rs_a - rs_b;
          OP_JMP: pc_d = PC_W'(imem_data[11:0]);
          OP_JZ: begin
            if (rs_a == '0) pc_d = pc_q + jz_off;
          end
          OP_LD, OP_ST: begin
            // Memory ops complete (and retire) in MEM, not here.
            pc_d      = pc_q;
            retired_d = retired_q;
            req_d     = 1'b1;
            we_d      = (op == OP_ST);
            addr_d    = rs_a;
            wdata_d   = rs_b;
            ld_rt_d   = rt;
            state_d   = S_MEM;
          end
          OP_HLT: begin
            // pc stays on the HLT address; the HLT itself is retired.
            pc_d    = pc_q;
            state_d = S_HALT;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        if (dmem_ready) begin
          if (!we_q) regs_d[ld_rt_q] = dmem_rdata;
          pc_d      = pc_inc;
          retired_d = retired_q + CNT_W'(1);
          req_d     = 1'b0;
          state_d   = S_RUN;
        end
      end
      default: ;
    endcase
  end

  // Architectural state registers; reset abandons any outstanding request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_RUN;
      pc_q      <= PC_W'(RESET_PC);
      retired_q <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ld_rt_q   <= '0;
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      ld_rt_q   <= ld_rt_d;
      for (int i = 0; i < 16; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign retired    = retired_q;
  assign halted     = (state_q == S_HALT);
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dbg_data   = regs_q[dbg_sel];

endmodule
`default_nettype wire
